// File: rtl/pin_entry_collector_pkg.sv
// Shared definitions for the parking gate PIN path: key codes, FSM state
// encoding, default timeout and small decode helpers.
package pin_entry_collector_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEFAULT_TMR_W          = 16;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned PW_W  = 8;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } pin_state_e;

  typedef enum logic [1:0] {
    KC_NONE  = 2'd0,
    KC_DIGIT = 2'd1,
    KC_CLEAR = 2'd2,
    KC_ENTER = 2'd3
  } key_class_e;

  // Assembled PIN: first digit in the high nibble.
  typedef struct packed {
    logic [NIB_W-1:0] hi;
    logic [NIB_W-1:0] lo;
  } pin_t;

  // Classify an accepted key; reserved codes never reach here as accepted.
  function automatic key_class_e classify_key(input logic accept, input logic [3:0] code);
    key_class_e kc;
    kc = KC_NONE;
    if (accept) begin
      if (code == KEY_CLEAR)      kc = KC_CLEAR;
      else if (code == KEY_ENTER) kc = KC_ENTER;
      else                        kc = KC_DIGIT;
    end
    return kc;
  endfunction

  // Digits held for a given FSM state, for the display.
  function automatic logic [CNT_W-1:0] state_digits(input pin_state_e s);
    logic [CNT_W-1:0] n;
    case (s)
      S_ONE:   n = CNT_W'(1);
      S_TWO:   n = CNT_W'(2);
      default: n = CNT_W'(0);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pin_entry_collector_if.sv
// Keypad-side inputs and controller-side outputs of the PIN collector.
interface pin_entry_collector_if;
  import pin_entry_collector_pkg::*;

  logic             sensor_entrance;
  logic             key_valid;
  logic [NIB_W-1:0] key_code;
  logic [PW_W-1:0]  input_password;
  logic             password_valid;
  logic             entry_error;
  logic [CNT_W-1:0] digit_count;

  modport master (
    output sensor_entrance, key_valid, key_code,
    input  input_password, password_valid, entry_error, digit_count
  );

  modport slave (
    input  sensor_entrance, key_valid, key_code,
    output input_password, password_valid, entry_error, digit_count
  );

endinterface

// File: rtl/pin_entry_timer.sv
// Inter-key timeout counter: cleared by clr, counts while run, and flags
// expiry when the count has reached TIMEOUT_CYCLES-1.
module pin_entry_timer
  import pin_entry_collector_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TMR_W          = DEFAULT_TMR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q, count_d;

  // Clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && (count_q == LAST_CNT);

endmodule

// File: rtl/pin_entry_collector.sv
// Two-digit BCD PIN collector for the parking gate entrance.
// Optional build macro KEY_EDGE_DETECT_EN: key_valid is a raw level and only
// its rising edge counts as a press; otherwise every high cycle is a press.
module pin_entry_collector
  import pin_entry_collector_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TMR_W          = DEFAULT_TMR_W
) (
  input logic                  clk,
  input logic                  reset,
  pin_entry_collector_if.slave bus
);

  pin_state_e       state_q, state_d;
  pin_t             pin_q, pin_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic             pv_q, pv_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  logic             key_strobe_c;
  logic             key_accept_c;
  key_class_e       key_class_c;
  logic             tmr_clr_c;
  logic             tmr_run_c;
  logic             tmr_expired;

`ifdef KEY_EDGE_DETECT_EN
  logic key_prev_q, key_prev_d;

  // Remember last key_valid level so a held key yields one press.
  always_comb begin
    key_prev_d = bus.key_valid;
  end

  // Edge-detect register; resets low so a level high at release is a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev_q <= 1'b0;
    end else begin
      key_prev_q <= key_prev_d;
    end
  end

  assign key_strobe_c = bus.key_valid & ~key_prev_q;
`else
  assign key_strobe_c = bus.key_valid;
`endif

  assign key_accept_c = key_strobe_c & bus.sensor_entrance & (bus.key_code <= KEY_ENTER);
  assign key_class_c  = classify_key(key_accept_c, bus.key_code);

  // Timer restarts on each accepted key and whenever the entry ends.
  assign tmr_clr_c = key_accept_c | (state_d == S_IDLE);
  assign tmr_run_c = (state_q != S_IDLE);

  pin_entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr_c),
    .run    (tmr_run_c),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: sensor drop aborts, then keys, then timeout.
  always_comb begin
    state_d = state_q;
    if (!bus.sensor_entrance) begin
      state_d = S_IDLE;
    end else begin
      case (key_class_c)
        KC_DIGIT: begin
          case (state_q)
            S_IDLE:  state_d = S_ONE;
            S_ONE:   state_d = S_TWO;
            default: state_d = S_IDLE;
          endcase
        end
        KC_CLEAR: state_d = S_IDLE;
        KC_ENTER: state_d = S_IDLE;
        default: begin
          if (tmr_expired) begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // Next values of nibbles, published PIN and strobes.
  always_comb begin
    pin_d  = pin_q;
    pw_d   = pw_q;
    pv_d   = 1'b0;
    err_d  = 1'b0;
    dcnt_d = state_digits(state_d);
    if (bus.sensor_entrance) begin
      case (key_class_c)
        KC_DIGIT: begin
          case (state_q)
            S_IDLE:  pin_d.hi = bus.key_code;
            S_ONE:   pin_d.lo = bus.key_code;
            default: err_d    = 1'b1;
          endcase
        end
        KC_ENTER: begin
          if (state_q == S_TWO) begin
            pv_d = 1'b1;
            pw_d = pin_q;
          end else begin
            err_d = 1'b1;
          end
        end
        KC_CLEAR: ;
        default: begin
          if (tmr_expired) begin
            err_d = 1'b1;
          end
        end
      endcase
    end
    // Partial digits never survive a return to IDLE.
    if (state_d == S_IDLE) begin
      pin_d = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pin_q  <= '0;
      pw_q   <= '0;
      pv_q   <= 1'b0;
      err_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      pin_q  <= pin_d;
      pw_q   <= pw_d;
      pv_q   <= pv_d;
      err_q  <= err_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign bus.input_password = pw_q;
  assign bus.password_valid = pv_q;
  assign bus.entry_error    = err_q;
  assign bus.digit_count    = dcnt_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Bench for pin_entry_collector: directed scenarios plus random keypad traffic,
// all checked every cycle against a queue-based model of the entry rules.
module tb_pin_entry_collector;
  import pin_entry_collector_pkg::*;

  localparam int unsigned TO = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pin_entry_collector_if bus();

  pin_entry_collector #(
    .TIMEOUT_CYCLES(TO),
    .TMR_W         (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits held as a queue, idle cycles counted since last key.
  int         m_digits[$];
  int         m_idle = 0;
  logic       m_prev = 1'b0;
  logic [7:0] m_pw   = 8'h00;
  logic       m_pv   = 1'b0;
  logic       m_err  = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    logic press;
    if (reset) begin
      m_digits.delete();
      m_idle = 0;
      m_prev = 1'b0;
      m_pw   = 8'h00;
      m_pv   = 1'b0;
      m_err  = 1'b0;
    end else begin
      press = bus.key_valid;
`ifdef KEY_EDGE_DETECT_EN
      press = bus.key_valid && !m_prev;
`endif
      m_prev = bus.key_valid;
      m_pv   = 1'b0;
      m_err  = 1'b0;
      if (!bus.sensor_entrance) begin
        m_digits.delete();
        m_idle = 0;
      end else if (press && int'(bus.key_code) <= 11) begin
        m_idle = 0;
        if (int'(bus.key_code) <= 9) begin
          if (m_digits.size() == 2) begin
            m_err = 1'b1;
            m_digits.delete();
          end else begin
            m_digits.push_back(int'(bus.key_code));
          end
        end else if (int'(bus.key_code) == 10) begin
          m_digits.delete();
        end else if (m_digits.size() == 2) begin
          m_pv = 1'b1;
          m_pw = 8'(m_digits[0] * 16 + m_digits[1]);
          m_digits.delete();
        end else begin
          m_err = 1'b1;
          m_digits.delete();
        end
      end else if (m_digits.size() > 0) begin
        m_idle++;
        if (m_idle == int'(TO)) begin
          m_err = 1'b1;
          m_digits.delete();
          m_idle = 0;
        end
      end
    end
  end

  int   cyc          = 0;
  int   pv_cnt       = 0;
  int   err_cnt      = 0;
  int   last_err_cyc = -1;
  logic cmp_en       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("input_password", int'(bus.input_password), int'(m_pw));
      check("password_valid", int'(bus.password_valid), int'(m_pv));
      check("entry_error",    int'(bus.entry_error),    int'(m_err));
      check("digit_count",    int'(bus.digit_count),    m_digits.size());
      check("strobe_overlap", int'(bus.password_valid & bus.entry_error), 0);
      if (bus.password_valid) pv_cnt++;
      if (bus.entry_error) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
    end
  end

  // Caller sits 2 time units after a rising edge; the key is sampled next edge.
  task automatic drive_key(input logic [3:0] code, input int gap);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk); #2;
    bus.key_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int e0, p0, kc, r, hold, gap;
    logic [3:0] code;
    bus.sensor_entrance = 1'b0;
    bus.key_valid       = 1'b0;
    bus.key_code        = 4'h0;
    #1 reset = 1'b1;
    #1;
    cmp_en = 1'b1;
    check("reset_password", int'(bus.input_password), 0);
    check("reset_valid",    int'(bus.password_valid), 0);
    check("reset_error",    int'(bus.entry_error),    0);
    check("reset_count",    int'(bus.digit_count),    0);
    @(posedge clk); #2;
    reset = 1'b0;
    bus.sensor_entrance = 1'b1;
    step(1);

    // 4, 9, ENTER five cycles apart.
    drive_key(4'h4, 4);
    check("t1_count_after_4", int'(bus.digit_count), 1);
    drive_key(4'h9, 4);
    check("t1_count_after_9", int'(bus.digit_count), 2);
    drive_key(KEY_ENTER, 0);
    check("t1_valid", int'(bus.password_valid), 1);
    check("t1_pin",   int'(bus.input_password), 8'h49);
    check("t1_count_after_enter", int'(bus.digit_count), 0);
    step(1);
    check("t1_valid_one_cycle", int'(bus.password_valid), 0);

    // 1, ENTER -> error, PIN unchanged.
    p0 = pv_cnt;
    drive_key(4'h1, 2);
    drive_key(KEY_ENTER, 0);
    check("t2_error", int'(bus.entry_error), 1);
    check("t2_valid", int'(bus.password_valid), 0);
    check("t2_pin_kept", int'(bus.input_password), 8'h49);
    step(1);
    check("t2_error_one_cycle", int'(bus.entry_error), 0);
    check("t2_no_valid", pv_cnt - p0, 0);

    // Overflow on a third digit, then 1, 2, ENTER.
    drive_key(4'h1, 1);
    drive_key(4'h2, 1);
    drive_key(4'h3, 0);
    check("t3_overflow_error", int'(bus.entry_error), 1);
    check("t3_overflow_count", int'(bus.digit_count), 0);
    step(1);
    drive_key(4'h1, 1);
    drive_key(4'h2, 1);
    drive_key(KEY_ENTER, 0);
    check("t3_pin", int'(bus.input_password), 8'h12);
    step(1);

    // Timeout: key sampled at edge K, error visible after edge K+TO.
    drive_key(4'h7, 0);
    kc = cyc;
    e0 = err_cnt;
    step(12);
    check("t4_timeout_count", err_cnt - e0, 1);
    check("t4_timeout_latency", last_err_cyc - kc, int'(TO));
    check("t4_idle_after", int'(bus.digit_count), 0);

    // Second digit sampled in the expiry cycle wins over the timeout.
    e0 = err_cnt;
    drive_key(4'h7, 7);
    drive_key(4'h3, 0);
    check("t5_count", int'(bus.digit_count), 2);
    check("t5_no_error", int'(bus.entry_error), 0);
    step(2);
    drive_key(KEY_ENTER, 1);
    check("t5_pin", int'(bus.input_password), 8'h73);
    check("t5_no_errors", err_cnt - e0, 0);

    // 3, CLEAR, 0, 5, ENTER.
    e0 = err_cnt;
    drive_key(4'h3, 1);
    drive_key(KEY_CLEAR, 1);
    check("t6_clear_count", int'(bus.digit_count), 0);
    drive_key(4'h0, 1);
    drive_key(4'h5, 1);
    drive_key(KEY_ENTER, 1);
    check("t6_pin", int'(bus.input_password), 8'h05);
    check("t6_no_error", err_cnt - e0, 0);

    // Sensor drop mid-entry, keys ignored while low.
    e0 = err_cnt;
    p0 = pv_cnt;
    drive_key(4'h6, 2);
    bus.sensor_entrance = 1'b0;
    step(1);
    check("t7_abort_count", int'(bus.digit_count), 0);
    drive_key(4'h1, 1);
    drive_key(4'h2, 1);
    drive_key(KEY_ENTER, 1);
    check("t7_ignored_count", int'(bus.digit_count), 0);
    check("t7_no_error", err_cnt - e0, 0);
    check("t7_no_valid", pv_cnt - p0, 0);
    bus.sensor_entrance = 1'b1;
    step(1);

    // Reset between two digits.
    drive_key(4'h5, 2);
    check("t8_before_reset", int'(bus.digit_count), 1);
    reset = 1'b1;
    #1;
    check("t8_reset_count", int'(bus.digit_count), 0);
    check("t8_reset_pin",   int'(bus.input_password), 0);
    check("t8_reset_valid", int'(bus.password_valid), 0);
    check("t8_reset_error", int'(bus.entry_error), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    step(1);

    // Held key_valid with code 8.
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h8;
`ifdef KEY_EDGE_DETECT_EN
    step(10);
    bus.key_valid = 1'b0;
    step(1);
    check("t9_held_one_digit", int'(bus.digit_count), 1);
`else
    step(2);
    bus.key_valid = 1'b0;
    step(1);
    check("t9_strobe_two_digits", int'(bus.digit_count), 2);
`endif
    drive_key(KEY_CLEAR, 1);

    // Random keypad traffic.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        bus.sensor_entrance = ~bus.sensor_entrance;
        step(1);
      end else if (r < 4) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end else begin
        code = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) code = KEY_ENTER;
        hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 3)) : 1;
        gap  = int'($urandom_range(0, 11));
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        step(hold);
        bus.key_valid = 1'b0;
        step(gap);
      end
    end
    bus.sensor_entrance = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
